// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter
//   Round-robin arbiter that shares one I2C master between Num_req local
//   requesters. One request is accepted at a time, launched on the master
//   with a single start pulse, and completed either by the master's done
//   pulse or by a timeout. A one-cycle response goes back to the owner.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   req_valid         : per-requester request pending (held until accepted)
//   req_rd_wr         : per-requester direction, 1 = read, 0 = write
//   req_addr          : packed slave addresses, requester i at [i*Address +: Address]
//   req_wdata         : packed write data, requester i at [i*Data_width +: Data_width]
//   req_ready         : one-hot combinational accept strobe (IDLE only)
//   rsp_valid         : one-hot one-cycle response strobe to the owner
//   rsp_rdata         : read data (0 for writes and timeouts), valid with rsp_valid
//   rsp_timeout       : transaction ended by timeout, valid with rsp_valid
//   m_start           : one-cycle start pulse to the I2C master
//   m_rd_wr, m_addr,
//   m_wdata           : captured transaction fields to the master
//   m_rdata, m_done   : master read data and completion pulse
//   busy              : registered, high whenever the arbiter is not idle
//   grant_id          : index of the current or most recent owner
module i2c_txn_arbiter #(
  parameter int Data_width = 8,
  parameter int Address    = 7,
  parameter int Num_req    = 4,
  parameter int Timeout    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [Num_req-1:0]            req_valid,
  input  logic [Num_req-1:0]            req_rd_wr,
  input  logic [Num_req*Address-1:0]    req_addr,
  input  logic [Num_req*Data_width-1:0] req_wdata,
  output logic [Num_req-1:0]            req_ready,
  output logic [Num_req-1:0]            rsp_valid,
  output logic [Data_width-1:0]         rsp_rdata,
  output logic                          rsp_timeout,
  output logic                          m_start,
  output logic                          m_rd_wr,
  output logic [Address-1:0]            m_addr,
  output logic [Data_width-1:0]         m_wdata,
  input  logic [Data_width-1:0]         m_rdata,
  input  logic                          m_done,
  output logic                          busy,
  output logic [$clog2(Num_req)-1:0]    grant_id
);

  localparam int IW = $clog2(Num_req);
  localparam int CW = $clog2(Timeout);
  localparam logic [CW-1:0] CNT_LAST = CW'(Timeout - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] cnt;

  logic          found;
  logic [IW-1:0] sel;
  logic [IW:0]   cand;

  logic [Address-1:0]    addr_arr  [Num_req];
  logic [Data_width-1:0] wdata_arr [Num_req];

  for (genvar gi = 0; gi < Num_req; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*Address +: Address];
    assign wdata_arr[gi] = req_wdata[gi*Data_width +: Data_width];
  end

  // Search starts at rr_ptr and wraps; cand is one bit wider so the sum
  // never overflows before the modulo correction.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < Num_req; i++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(Num_req)) begin
        cand = cand - (IW+1)'(Num_req);
      end
      if (!found && req_valid[cand[IW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IW-1:0];
      end
    end
  end

  // Gated by rst so no accept is signalled while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst && (state == S_IDLE) && found) begin
      req_ready[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      cnt         <= '0;
      m_start     <= 1'b0;
      m_rd_wr     <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      m_start   <= 1'b0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            state    <= S_LAUNCH;
            m_start  <= 1'b1;
            busy     <= 1'b1;
            grant_id <= sel;
            rr_ptr   <= (sel == IW'(Num_req - 1)) ? '0 : sel + 1'b1;
            m_rd_wr  <= req_rd_wr[sel];
            m_addr   <= addr_arr[sel];
            m_wdata  <= wdata_arr[sel];
          end
        end
        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // Completion takes priority over a timeout landing in the same cycle.
          if (m_done) begin
            rsp_rdata   <= m_rd_wr ? m_rdata : '0;
            rsp_timeout <= 1'b0;
            rsp_valid   <= Num_req'(1) << grant_id;
            state       <= S_RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= Num_req'(1) << grant_id;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
module tb_i2c_txn_arbiter;
  localparam int NR  = 4;
  localparam int AW  = 7;
  localparam int DW  = 8;
  localparam int TMO = 16;
  localparam int IW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0]    req_valid, req_rd_wr, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, m_wdata, m_rdata;
  logic             rsp_timeout, m_start, m_rd_wr, m_done, busy;
  logic [AW-1:0]    m_addr;
  logic [IW-1:0]    grant_id;

  int tests  = 0;
  int errors = 0;

  i2c_txn_arbiter #(.Data_width(DW), .Address(AW), .Num_req(NR), .Timeout(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd_wr(req_rd_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .m_start(m_start), .m_rd_wr(m_rd_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: timestamps per transaction ----------------
  int            cyc = 0;
  bit            in_flight = 0;
  int            t_acc = 0, resp_at = -1, owner = 0, rr = 0, last_start = -100;
  logic [IW-1:0] e_gid = '0;
  logic          e_rd = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wd = '0, r_data = '0;
  logic          r_to = 1'b0;

  always @(negedge clk) begin : cmp
    logic [NR-1:0] e_ready, e_rv;
    logic e_start, e_busy;
    int ph, g, j;
    bit found;
    e_ready = '0; e_rv = '0; e_start = 1'b0; e_busy = 1'b0; ph = 0; g = 0; j = 0; found = 0;
    if (!rst) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_m_start", 32'(m_start), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_grant_id", 32'(grant_id), 0);
      chk("rst_m_addr", 32'(m_addr), 0);
      chk("rst_m_wdata", 32'(m_wdata), 0);
      chk("rst_m_rd_wr", 32'(m_rd_wr), 0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
      chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
      in_flight = 0; rr = 0; e_gid = '0; e_rd = 1'b0; e_addr = '0; e_wd = '0;
      resp_at = -1; last_start = -100;
    end else begin
      if (in_flight) begin
        ph = cyc - t_acc;
        e_busy = 1'b1;
        e_start = (ph == 1);
        if (resp_at == cyc) e_rv = NR'(1) << owner;
      end else begin
        for (int i = 0; i < NR; i++) begin
          j = (rr + i) % NR;
          if (!found && 1'(req_valid >> j)) begin
            found = 1;
            g = j;
          end
        end
        if (found) e_ready = NR'(1) << g;
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("m_start", 32'(m_start), 32'(e_start));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("grant_id", 32'(grant_id), 32'(e_gid));
      chk("m_addr", 32'(m_addr), 32'(e_addr));
      chk("m_wdata", 32'(m_wdata), 32'(e_wd));
      chk("m_rd_wr", 32'(m_rd_wr), 32'(e_rd));
      if (e_rv != '0) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'(r_data));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(r_to));
      end
      if (m_start) begin
        chk("start_spacing_ge4", 32'(cyc - last_start >= 4), 1);
        last_start = cyc;
      end
      // advance model to the next cycle
      if (in_flight) begin
        if (resp_at == cyc) begin
          in_flight = 0;
        end else if (resp_at < 0 && ph >= 2) begin
          if (m_done) begin
            resp_at = cyc + 1; r_to = 1'b0; r_data = e_rd ? m_rdata : '0;
          end else if (ph == TMO + 1) begin
            resp_at = cyc + 1; r_to = 1'b1; r_data = '0;
          end
        end
      end else if (found) begin
        in_flight = 1; t_acc = cyc; owner = g; resp_at = -1;
        e_gid  = IW'(g);
        e_rd   = 1'(req_rd_wr >> g);
        e_addr = AW'(req_addr >> (g * AW));
        e_wd   = DW'(req_wdata >> (g * DW));
        rr     = (g + 1) % NR;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  logic [NR-1:0] s_ready, s_rsp;
  logic          s_start, s_busy, s_to;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [AW-1:0] s_addr;
  logic [IW-1:0] s_gid;
  bit keep_valid = 0, rand_mode = 0, force_done = 0;
  int next_k = 2, mcd = 0;

  task automatic set_req(input int i, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rd_wr = (req_rd_wr & ~(NR'(1) << i)) | (NR'(rd) << i);
    req_addr  = (req_addr & ~((NR*AW)'({AW{1'b1}}) << (i * AW))) | ((NR*AW)'(a) << (i * AW));
    req_wdata = (req_wdata & ~((NR*DW)'({DW{1'b1}}) << (i * DW))) | ((NR*DW)'(d) << (i * DW));
  endtask

  // Sample the current cycle at negedge, then move to just after the next
  // rising edge and drive that cycle's inputs (master emulation + requesters).
  task automatic tick();
    @(negedge clk);
    s_ready = req_ready; s_rsp = rsp_valid; s_start = m_start; s_busy = busy;
    s_to = rsp_timeout; s_rdata = rsp_rdata; s_addr = m_addr; s_wdata = m_wdata; s_gid = grant_id;
    @(posedge clk);
    #1;
    if (rand_mode) begin
      case ($urandom % 8)
        0:       next_k = 0;
        1:       next_k = TMO;
        default: next_k = 1 + int'($urandom % 6);
      endcase
      force_done = ($urandom % 16 == 0);
      m_rdata = DW'($urandom);
    end
    if (s_start) mcd = next_k;
    m_done = force_done;
    if (mcd > 0) begin
      mcd--;
      if (mcd == 0) m_done = 1'b1;
    end
    if (!keep_valid) req_valid = req_valid & ~s_ready;
    if (rand_mode) begin
      for (int i = 0; i < NR; i++) begin
        if (1'(req_valid >> i)) begin
          if ($urandom % 40 == 0) req_valid = req_valid & ~(NR'(1) << i);
        end else if ($urandom % 3 == 0) begin
          set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
          req_valid = req_valid | (NR'(1) << i);
        end else begin
          set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
        end
      end
    end
  endtask

  task automatic observe_txn(output logic [NR-1:0] rdy, output logic [IW-1:0] gid,
                             output int sdly, output int rdly, output logic [NR-1:0] rv,
                             output logic [DW-1:0] rd, output logic to,
                             output logic [AW-1:0] a, output logic [DW-1:0] wd);
    int n;
    rdy = '0; gid = '0; sdly = -1; rdly = -1; rv = '0; rd = '0; to = 1'b0; a = '0; wd = '0;
    n = 0;
    do begin tick(); n++; end while (s_ready == '0 && n < 60);
    if (s_ready == '0) begin
      chk("accept_wait_expired", 32'(s_ready != '0), 1);
      return;
    end
    rdy = s_ready;
    n = 0;
    do begin tick(); n++; end while (!s_start && n < 10);
    sdly = n; a = s_addr; wd = s_wdata; gid = s_gid;
    n = 0;
    do begin tick(); n++; end while (s_rsp == '0 && n < 100);
    rdly = n; rv = s_rsp; rd = s_rdata; to = s_to;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin tick(); n++; end while (s_busy && n < 100);
    chk("idle_wait", 32'(s_busy), 0);
  endtask

  function automatic int onehot_idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (1'(v >> i)) r = i;
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] rdy, rv;
    logic [IW-1:0] gid;
    int sdly, rdly, n_gr, n;
    logic [DW-1:0] rd, wd;
    logic to;
    logic [AW-1:0] a;
    int order[6];
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};
    order = '{-1, -1, -1, -1, -1, -1};
    req_valid = '0; req_rd_wr = '0; req_addr = '0; req_wdata = '0;
    m_rdata = '0; m_done = 1'b0;

    // reset with all requesters asking: no accept may show
    rst = 1'b0;
    req_valid = '1;
    repeat (3) tick();
    chk("reset_ready_held_low", 32'(s_ready), 0);
    chk("reset_busy", 32'(s_busy), 0);
    req_valid = '0;
    rst = 1'b1;

    // round-robin fairness, all four holding valid
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(16 + i), DW'(32 + i));
    req_valid = '1; keep_valid = 1; next_k = 2; n_gr = 0;
    for (int c = 0; c < 80 && n_gr < 6; c++) begin
      tick();
      if (s_ready != '0) begin
        order[n_gr] = onehot_idx(s_ready);
        n_gr++;
      end
    end
    req_valid = '0; keep_valid = 0;
    chk("fair_grant_count", n_gr, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("fair_order_%0d", i), order[i], exp_order[i]);
    wait_idle();

    // single write from requester 2, done 10 cycles after start
    m_rdata = 8'hEE;
    set_req(2, 1'b0, 7'h50, 8'hA5); req_valid = 4'b0100; next_k = 10;
    observe_txn(rdy, gid, sdly, rdly, rv, rd, to, a, wd);
    chk("wr_ready", 32'(rdy), 32'h4);
    chk("wr_start_dly", sdly, 1);
    chk("wr_m_addr", 32'(a), 32'h50);
    chk("wr_m_wdata", 32'(wd), 32'hA5);
    chk("wr_grant_id", 32'(gid), 2);
    chk("wr_rsp_dly", rdly, 11);
    chk("wr_rsp_valid", 32'(rv), 32'h4);
    chk("wr_rdata", 32'(rd), 0);
    chk("wr_timeout", 32'(to), 0);

    // single read from requester 0
    m_rdata = 8'h7E;
    set_req(0, 1'b1, 7'h3C, 8'h00); req_valid = 4'b0001; next_k = 5;
    observe_txn(rdy, gid, sdly, rdly, rv, rd, to, a, wd);
    chk("rd_ready", 32'(rdy), 32'h1);
    chk("rd_m_addr", 32'(a), 32'h3C);
    chk("rd_rsp_dly", rdly, 6);
    chk("rd_rsp_valid", 32'(rv), 32'h1);
    chk("rd_rdata", 32'(rd), 32'h7E);
    chk("rd_timeout", 32'(to), 0);

    // timeout on requester 1, requester 3 queued behind it
    set_req(1, 1'b1, 7'h22, 8'h11); set_req(3, 1'b0, 7'h33, 8'h44);
    req_valid = 4'b1010; next_k = 0;
    observe_txn(rdy, gid, sdly, rdly, rv, rd, to, a, wd);
    chk("to_ready", 32'(rdy), 32'h2);
    chk("to_rsp_dly", rdly, 17);
    chk("to_rsp_valid", 32'(rv), 32'h2);
    chk("to_timeout", 32'(to), 1);
    chk("to_rdata", 32'(rd), 0);
    next_k = 3;
    observe_txn(rdy, gid, sdly, rdly, rv, rd, to, a, wd);
    chk("after_to_ready", 32'(rdy), 32'h8);
    chk("after_to_grant_id", 32'(gid), 3);
    chk("after_to_start_dly", sdly, 1);
    chk("after_to_m_addr", 32'(a), 32'h33);
    chk("after_to_rsp_dly", rdly, 4);
    chk("after_to_rsp_valid", 32'(rv), 32'h8);
    chk("after_to_timeout", 32'(to), 0);

    // done coincident with the last timeout cycle
    m_rdata = 8'h5A;
    set_req(2, 1'b1, 7'h45, 8'h00); req_valid = 4'b0100; next_k = TMO;
    observe_txn(rdy, gid, sdly, rdly, rv, rd, to, a, wd);
    chk("edge_rsp_dly", rdly, 17);
    chk("edge_timeout", 32'(to), 0);
    chk("edge_rdata", 32'(rd), 32'h5A);

    // spurious done while idle
    for (int c = 0; c < 6; c++) begin
      force_done = (c < 4);
      tick();
      chk("spurious_rsp_valid", 32'(s_rsp), 0);
      chk("spurious_busy", 32'(s_busy), 0);
    end
    force_done = 0;

    // reset asserted while waiting for the master
    set_req(1, 1'b0, 7'h11, 8'h99); req_valid = 4'b0010; next_k = 0;
    n = 0;
    do begin tick(); n++; end while (!s_start && n < 20);
    chk("rstwait_started", 32'(s_start), 1);
    repeat (3) tick();
    set_req(3, 1'b0, 7'h2B, 8'h3D);
    req_valid = 4'b1000;
    rst = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_m_start", 32'(m_start), 0);
    chk("async_rsp_valid", 32'(rsp_valid), 0);
    chk("async_grant_id", 32'(grant_id), 0);
    chk("async_m_addr", 32'(m_addr), 0);
    chk("async_m_wdata", 32'(m_wdata), 0);
    chk("async_req_ready", 32'(req_ready), 0);
    repeat (2) tick();
    rst = 1'b1;
    next_k = 2;
    observe_txn(rdy, gid, sdly, rdly, rv, rd, to, a, wd);
    chk("post_rst_ready", 32'(rdy), 32'h8);
    chk("post_rst_grant_id", 32'(gid), 3);
    chk("post_rst_rsp_valid", 32'(rv), 32'h8);
    set_req(0, 1'b0, 7'h01, 8'h02); set_req(2, 1'b0, 7'h03, 8'h04);
    req_valid = 4'b0101;
    observe_txn(rdy, gid, sdly, rdly, rv, rd, to, a, wd);
    chk("rr_wrapped_to_0", 32'(rdy), 32'h1);
    req_valid = '0;
    wait_idle();

    // randomized traffic against the model
    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0;
    req_valid = '0;
    force_done = 0;
    next_k = 2;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Round-robin transaction arbiter that shares a single I2C master between `Num_req` requesters. It accepts one request at a time and launches it on the master's start/rd_wr/address/data inputs. It then waits for the master's done pulse, or a timeout, and returns a one-cycle response to the requester that issued the transaction. It sits between local client logic and the I2C master instance.

## Interface
- `Data_width`, 8: data byte width.
- `Address`, 7: slave address width.
- `Num_req`, 4: number of requesters, 2..8.
- `Timeout`, 1024: cycles to wait for `m_done` before aborting, ≥ 4.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input `Num_req`: per-requester request pending; held until accepted.
- `req_rd_wr` input `Num_req`: per-requester direction, 1 = read, 0 = write.
- `req_addr` input `Num_req*Address`: packed addresses; requester i uses bits [i*Address +: Address].
- `req_wdata` input `Num_req*Data_width`: packed write data, same packing scheme.
- `req_ready` output `Num_req`: one-hot accept pulse.
- `rsp_valid` output `Num_req`: one-hot, one-cycle response pulse to the owning requester.
- `rsp_rdata` output `Data_width`: read data, valid with `rsp_valid`.
- `rsp_timeout` output 1: transaction aborted by timeout, valid with `rsp_valid`.
- `m_start` output 1: start pulse to the I2C master.
- `m_rd_wr` output 1: direction to the master.
- `m_addr` output `Address`: slave address to the master.
- `m_wdata` output `Data_width`: write data to the master.
- `m_rdata` input `Data_width`: master read data.
- `m_done` input 1: master transaction-complete pulse.
- `busy` output 1: high in any state other than IDLE.
- `grant_id` output `$clog2(Num_req)`: index of the current or last owner.

## Operation
- States:
  - IDLE: search `req_valid` starting at `rr_ptr`, wrapping modulo `Num_req`. If a requester g is found:
    - `req_ready[g]` = 1 in the same cycle (combinational).
    - Capture `req_rd_wr[g]`, addr and wdata into registers.
    - `grant_id` <= g, `rr_ptr` <= (g+1) mod `Num_req`.
    - Go to LAUNCH.
    - If no requester is valid, stay in IDLE.
  - LAUNCH: `m_start` = 1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: the counter increments every cycle.
    - `m_done` = 1: capture `m_rdata` (forced to 0 for writes), `rsp_timeout` <= 0, go to RESP.
    - Otherwise, when the counter equals `Timeout-1`: `rsp_rdata` <= 0, `rsp_timeout` <= 1, go to RESP.
    - If both happen in the same cycle, `m_done` wins.
  - RESP: `rsp_valid[grant_id]` = 1 for one cycle. Go to IDLE.
- `m_rd_wr`, `m_addr` and `m_wdata` are driven from the captured registers. They are stable from LAUNCH through RESP and hold their last value in IDLE.
- `m_done` is ignored in IDLE, LAUNCH and RESP.
- `req_*` changes after acceptance do not affect the transaction in flight.
- `req_valid` deasserted before acceptance is a legal withdrawal; no grant is issued.
- The arbiter never resets or aborts the I2C master. After a timeout, the next transaction is still launched normally.

## Timing
- Reset values (asserted asynchronously):
  - State IDLE; `rr_ptr` = 0; `grant_id` = 0.
  - `m_start`, `m_rd_wr`, `m_addr`, `m_wdata` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_timeout` = 0; `busy` = 0; counter = 0.
  - `req_ready` = 0 while `rst` is low.
- Reset mid-transaction: return to IDLE immediately. No response is issued for the aborted request.
- Accept in cycle T:
  - `m_start` high in T+1.
  - If `m_done` is first seen in cycle T+1+k (k ≥ 1), `rsp_valid` is high in T+2+k.
  - Timeout: `m_done` never arrives → `rsp_valid` high in T+2+`Timeout`.
- Back-to-back:
  - Earliest next accept is the cycle after RESP.
  - Minimum spacing between `m_start` pulses is 4 cycles.
- `busy` is registered: high from T+1 through the RESP cycle.

## Test plan
- Single write: requester 2 asserts valid, addr 0x50, wdata 0xA5, rd_wr 0; master asserts `m_done` 10 cycles after `m_start`.
  - `req_ready` = 0100 in the accept cycle.
  - One `m_start` pulse with `m_addr` = 0x50, `m_wdata` = 0xA5.
  - `rsp_valid` = 0100 one cycle after `m_done`, with `rsp_rdata` = 0 and `rsp_timeout` = 0.
- Single read: requester 0 reads addr 0x3C; master returns `m_rdata` = 0x7E with `m_done`.
  - `rsp_valid` = 0001, `rsp_rdata` = 0x7E.
- Round-robin fairness: all 4 requesters hold valid continuously.
  - Grant order 0,1,2,3,0,1.
  - Each `rsp_valid` goes to the matching requester.
  - `m_start` pulses are never closer than 4 cycles apart.
- Timeout: `Timeout` = 16, master never asserts `m_done`.
  - `rsp_valid` is high exactly 17 cycles after `m_start`, with `rsp_timeout` = 1 and `rsp_rdata` = 0.
  - The next queued request launches normally afterwards.
- Edge cases:
  - `m_done` coincident with the last timeout cycle → `rsp_timeout` = 0.
  - Spurious `m_done` in IDLE → no response.
  - `rst` pulled low in WAIT → all outputs go to their reset values asynchronously and no `rsp_valid` is issued.
  - After reset release, requester 3 alone is granted, and `rr_ptr` becomes 0.
